// File: rtl/vga_line_fetch.sv
// Fetches a low-resolution frame one source row at a time into a two-bank line
// buffer and emits pixel-replicated output with syncs delayed to stay aligned.
module vga_line_fetch #(
  parameter int H_DISPLAY   = 1280,
  parameter int V_DISPLAY   = 960,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [11:0]       h_count,
  input  logic [11:0]       v_count,
  input  logic              display_en,
  input  logic              h_sync,
  input  logic              v_sync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_h_sync,
  output logic              pix_v_sync,
  output logic              underrun
);
  localparam int SRC_W = H_DISPLAY >> SCALE_SHIFT;
  localparam int SRC_H = V_DISPLAY >> SCALE_SHIFT;
  localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam logic [11:0] ROW_MASK = 12'((1 << SCALE_SHIFT) - 1);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic              r_bank, w_bank_nxt;
  logic              r_underrun, w_underrun_nxt;

  logic [11:0] w_src_row;
  logic [11:0] w_rd_col;
  logic [COL_W-1:0] w_rd_idx;
  logic w_row0_trig, w_chk_pt, w_next_trig, w_wr;

  assign w_src_row   = v_count >> SCALE_SHIFT;
  assign w_rd_col    = h_count >> SCALE_SHIFT;
  assign w_rd_idx    = w_rd_col[COL_W-1:0];
  assign w_row0_trig = (h_count == 12'd0) && (v_count == 12'(V_DISPLAY));
  // First line of each visible source row: where the next row's fetch must begin.
  assign w_chk_pt    = (h_count == 12'd0) && (v_count < 12'(V_DISPLAY)) &&
                       ((v_count & ROW_MASK) == 12'd0);
  assign w_next_trig = w_chk_pt && (w_src_row < 12'(SRC_H - 1));
  assign w_wr        = (r_state == S_FETCH) && mem_ack;

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_col_nxt      = r_col;
    w_bank_nxt     = r_bank;
    w_underrun_nxt = r_underrun;
    case (r_state)
      S_IDLE: begin
        if (w_row0_trig) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_bank_nxt  = 1'b0;
          w_col_nxt   = '0;
        end else if (w_next_trig) begin
          w_state_nxt = S_FETCH;
          w_bank_nxt  = ~w_src_row[0];
          w_col_nxt   = '0;
        end
      end
      S_FETCH: begin
        if (w_row0_trig || w_chk_pt) w_underrun_nxt = 1'b1;
        if (mem_ack) begin
          w_addr_nxt = r_addr + 1'b1;
          w_col_nxt  = r_col + 1'b1;
          if (r_col == COL_W'(SRC_W - 1)) begin
            w_state_nxt = S_IDLE;
            w_col_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_col      <= '0;
      r_bank     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_col      <= w_col_nxt;
      r_bank     <= w_bank_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  logic [PIX_W-1:0] r_bank0 [SRC_W];
  logic [PIX_W-1:0] r_bank1 [SRC_W];
  logic [PIX_W-1:0] r_rd_data;

  // Non-blocking read/write gives old data on a same-bank collision.
  always_ff @(posedge clk_in) begin
    if (w_wr && !r_bank) r_bank0[r_col] <= mem_data;
    if (w_wr &&  r_bank) r_bank1[r_col] <= mem_data;
    if (w_rd_col >= 12'(SRC_W)) r_rd_data <= '0;
    else if (w_src_row[0])      r_rd_data <= r_bank1[w_rd_idx];
    else                        r_rd_data <= r_bank0[w_rd_idx];
  end

  logic             r_en_d1, r_hs_d1, r_vs_d1, r_hs_d2, r_vs_d2;
  logic [PIX_W-1:0] r_pix;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_en_d1 <= 1'b0;
      r_hs_d1 <= 1'b1;
      r_vs_d1 <= 1'b1;
      r_hs_d2 <= 1'b1;
      r_vs_d2 <= 1'b1;
      r_pix   <= '0;
    end else begin
      r_en_d1 <= display_en;
      r_hs_d1 <= h_sync;
      r_vs_d1 <= v_sync;
      r_hs_d2 <= r_hs_d1;
      r_vs_d2 <= r_vs_d1;
      r_pix   <= r_en_d1 ? r_rd_data : '0;
    end
  end

  assign mem_req    = (r_state == S_FETCH);
  assign mem_addr   = r_addr;
  assign pix_out    = r_pix;
  assign pix_h_sync = r_hs_d2;
  assign pix_v_sync = r_vs_d2;
  assign underrun   = r_underrun;
endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: expected fetch addresses and delayed
// pixels/syncs are queued as stimulus is driven and popped as the DUT answers.
module tb_vga_line_fetch;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 8;
  localparam int SS     = 2;
  localparam int SRC_W  = 320;
  localparam int SRC_H  = 240;
  localparam int V_DISP = 960;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [11:0]       h_count, v_count;
  logic              display_en, h_sync, v_sync;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data, pix_out;
  logic              pix_h_sync, pix_v_sync, underrun;

  always #5 clk_in = ~clk_in;

  vga_line_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .h_count(h_count), .v_count(v_count),
    .display_en(display_en), .h_sync(h_sync), .v_sync(v_sync),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pix_out(pix_out), .pix_h_sync(pix_h_sync), .pix_v_sync(pix_v_sync),
    .underrun(underrun)
  );

  typedef struct {int due; logic [7:0] pix; logic hs; logic vs;} px_t;
  px_t px_q[$];
  int  addr_q[$];
  int  total = 0, bad = 0, cyc = 0;
  int  ack_mode;
  int  bank_base[2];
  int  next_addr;
  bit  busy, busy_clr, exp_uf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic start_fetch(input int bank, input int base);
    bank_base[bank] = base;
    for (int i = 0; i < SRC_W; i++) addr_q.push_back((base + i) % (1 << ADDR_W));
    next_addr = (base + SRC_W) % (1 << ADDR_W);
    busy = 1'b1;
  endtask

  // One clock: check outputs just after the edge, then answer the memory port.
  task automatic step();
    @(posedge clk_in); #1;
    cyc++;
    if (busy_clr) begin busy = 1'b0; busy_clr = 1'b0; end
    chk("underrun", underrun, exp_uf);
    while (px_q.size() > 0 && px_q[0].due == cyc) begin
      px_t e;
      e = px_q.pop_front();
      chk("pix", pix_out, e.pix);
      chk("hsync", pix_h_sync, e.hs);
      chk("vsync", pix_v_sync, e.vs);
    end
    mem_ack  = 1'b0;
    mem_data = '0;
    if (mem_req) begin
      if (addr_q.size() == 0) chk("req_unexp", mem_req, 0);
      else begin
        chk("addr", mem_addr, addr_q[0]);
        if (ack_mode == 1 || (ack_mode == 3 && cyc % 3 == 0)) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr[7:0];
          void'(addr_q.pop_front());
          if (addr_q.size() == 0) busy_clr = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input int h, input int v, input bit en, input bit hs, input bit vs);
    px_t e;
    h_count = 12'(h); v_count = 12'(v); display_en = en; h_sync = hs; v_sync = vs;
    if (!rst_in) begin
      e.due = cyc + 2;
      e.pix = en ? 8'(bank_base[(v >> SS) & 1] + (h >> SS)) : 8'd0;
      e.hs  = hs;
      e.vs  = vs;
      px_q.push_back(e);
    end
    if (h == 0 && v == V_DISP) begin
      if (busy) exp_uf = 1'b1;
      else start_fetch(0, 0);
    end else if (h == 0 && v < V_DISP && (v % (1 << SS)) == 0) begin
      if (busy) exp_uf = 1'b1;
      else if ((v >> SS) < SRC_H - 1) start_fetch(((v >> SS) + 1) & 1, next_addr);
    end
  endtask

  task automatic line(input int v, input bit vis);
    for (int h = 0; h < 1300; h++) begin
      drive(h, v, vis && h < 1280, !(h >= 1290 && h < 1296), 1'b1);
      step();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    rst_in = 1'b1; mem_ack = 1'b0; mem_data = '0; ack_mode = 1;
    busy = 0; busy_clr = 0; exp_uf = 0; next_addr = 0;
    bank_base[0] = 0; bank_base[1] = 0;
    h_count = 12'd1300; v_count = 12'd970; display_en = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_hs", pix_h_sync, 1);
    chk("rst_vs", pix_v_sync, 1);
    chk("rst_uf", underrun, 0);
    rst_in = 1'b0;
    drive(1300, 970, 0, 1, 1);
    step(); step();

    // Row 0, memory acking every cycle.
    drive(0, V_DISP, 0, 1, 1);
    step();
    chk("row0_req_rise", mem_req, 1);
    drive(1300, V_DISP, 0, 1, 1);
    wait_idle("row0_done", 400);
    chk("row0_req_fall", mem_req, 0);
    chk("row0_addr_end", mem_addr, 320);

    // Display line 0 from bank 0 while row 1 fetches into bank 1.
    line(0, 1'b1);
    chk("row1_done", busy, 0);
    chk("row1_addr_end", mem_addr, 640);

    // Stalling memory: row 2 into bank 0 while lines 4..7 show bank 1.
    ack_mode = 3;
    for (int v = 4; v < 8; v++) line(v, 1'b1);
    chk("stall_budget", busy, 0);
    chk("row2_addr_end", mem_addr, 960);
    chk("stall_uf", underrun, 0);

    // Underrun: memory never acks through the next check point.
    ack_mode = 0;
    drive(0, 8, 0, 1, 0);
    step();
    drive(5, 8, 0, 1, 0);
    repeat (10) step();
    chk("uf_req_held", mem_req, 1);
    chk("uf_addr_held", mem_addr, 960);
    drive(0, 12, 0, 1, 0);
    step();
    drive(5, 12, 0, 1, 0);
    repeat (5) step();
    chk("uf_set", underrun, 1);
    ack_mode = 1;
    wait_idle("uf_row_done", 400);
    repeat (20) step();
    chk("uf_no_refetch", mem_req, 0);
    chk("uf_addr_end", mem_addr, 1280);
    chk("uf_sticky", underrun, 1);

    // Async reset in the middle of a row-0 fetch.
    drive(0, V_DISP, 0, 1, 1);
    step();
    drive(1300, V_DISP, 0, 1, 1);
    for (int n = 0; n < 400; n++) begin
      step();
      if (mem_addr == ADDR_W'(100)) break;
    end
    chk("reach_addr100", mem_addr, 100);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_pix", pix_out, 0);
    chk("arst_hs", pix_h_sync, 1);
    chk("arst_vs", pix_v_sync, 1);
    chk("arst_uf", underrun, 0);
    addr_q.delete(); px_q.delete();
    busy = 0; busy_clr = 0; exp_uf = 0; next_addr = 0; mem_ack = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    drive(1300, V_DISP, 0, 1, 1);
    step(); step();
    chk("post_rst_idle", mem_req, 0);
    drive(0, V_DISP, 0, 1, 1);
    step();
    chk("restart_req", mem_req, 1);
    drive(1300, V_DISP, 0, 1, 1);
    wait_idle("restart_done", 400);
    chk("restart_addr_end", mem_addr, 320);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
